// File: rtl/mul32_shift_add_unit.sv
// Radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes and the sign is fixed up at the end.

module carry_lookahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out,
  output logic       done
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  // Lookahead carries computed directly from generate/propagate terms
  always_comb begin
    w_p = a ^ b;
    w_g = a & b;
    w_c[0] = carry_in;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0])
           | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1])
           | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    sum       = w_p ^ w_c[3:0];
    carry_out = w_c[4];
    done      = 1'b1;
  end
endmodule

module mul32_shift_add_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);
  localparam int NS = WIDTH / 4;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [NS:0]        w_carry;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic               w_accept;
  logic [2*WIDTH-1:0] w_full;
  logic [2*WIDTH-1:0] w_fixed;

  // Operand preparation and handshake decode
  always_comb begin
    w_accept = in_valid & (r_state == S_IDLE);
    w_neg    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    w_abs_a  = (in_signed & in_a[WIDTH-1]) ? (~in_a + ONE_W) : in_a;
    w_abs_b  = (in_signed & in_b[WIDTH-1]) ? (~in_b + ONE_W) : in_b;
    w_addend = r_lo[0] ? r_mcand : '0;
    w_full   = {r_hi, r_lo};
    w_fixed  = r_neg ? (~w_full + ONE_2W) : w_full;
  end

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_cla
      carry_lookahead_adder_4bit u_cla (
        .a         (r_hi[4*gi +: 4]),
        .b         (w_addend[4*gi +: 4]),
        .carry_in  (w_carry[gi]),
        .sum       (w_sum[4*gi +: 4]),
        .carry_out (w_carry[gi+1]),
        .done      ()
      );
    end
  endgenerate

  // FSM plus shift-add datapath; one multiplier bit consumed per CALC cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= in_signed ? w_abs_a : in_a;
            r_lo    <= in_signed ? w_abs_b : in_b;
            r_hi    <= '0;
            r_neg   <= w_neg;
            r_count <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          {r_hi, r_lo} <= {w_carry[NS], w_sum, r_lo[WIDTH-1:1]};
          r_count      <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_product <= w_fixed;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign out_product = r_product;

endmodule

// File: tb/tb_mul32_shift_add_unit.sv
// Directed bench for mul32_shift_add_unit.
// Hand-computed products, latency, backpressure and mid-op reset.

module tb_mul32_shift_add_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] out_product;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  mul32_shift_add_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands, accept at the next edge, then scramble inputs
  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic s,
                       input string tag);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_signed = ~s;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
  endtask

  // Count edges after accept until out_valid, bounded
  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic s,
                     input logic [63:0] exp,
                     input string tag);
    issue(a, b, s, tag);
    wait_done(tag);
    chk({tag, "_product"}, out_product, exp);
    drain();
    chk({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_product", out_product, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "u3x5");
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
        64'hFFFF_FFFE_0000_0001, "uffxff");
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
        64'h0000_0000_0000_0001, "sm1xm1");
    run(32'h8000_0000, 32'h8000_0000, 1'b1,
        64'h4000_0000_0000_0000, "sminxmin");
    run(32'hFFFF_FFF9, 32'd3, 1'b1,
        64'hFFFF_FFFF_FFFF_FFEB, "sm7x3");
    run(32'h8000_0000, 32'd2, 1'b0,
        64'h0000_0001_0000_0000, "u8x2");
    run(32'h8000_0000, 32'd1, 1'b1,
        64'hFFFF_FFFF_8000_0000, "sminx1");
    run(32'h8000_0000, 32'h8000_0000, 1'b0,
        64'h4000_0000_0000_0000, "uminxmin");
    run(32'd0, 32'h1234_5678, 1'b0, 64'd0, "u0xn");
    run(32'd100, 32'hFFFF_FFFE, 1'b1,
        64'hFFFF_FFFF_FFFF_FF38, "s100xm2");

    // Backpressure: hold result while a new request waits
    issue(32'd9, 32'd11, 1'b0, "bp");
    wait_done("bp");
    held = out_product;
    chk("bp_product", held, 64'd99);
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd6; in_b = 32'd4; in_signed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_prod", out_product, held);
      chk("bp_no_accept", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_idle", {63'd0, in_ready}, 64'd1);
    chk("bp_release_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept", {63'd0, busy}, 64'd1);
    wait_done("bp_next");
    chk("bp_next_product", out_product, 64'd24);
    drain();

    // Reset in the middle of CALC
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mid");
    repeat (W / 2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_product", out_product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rel_ready", {63'd0, in_ready}, 64'd1);
    run(32'd6, 32'd7, 1'b0, 64'd42, "after_rst");

    // Random operands against a wide-multiply reference
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs)
        exp = 64'($signed({{32{ra[W-1]}}, ra}) *
                  $signed({{32{rb[W-1]}}, rb}));
      else
        exp = {32'd0, ra} * {32'd0, rb};
      issue(ra, rb, rs, "rnd");
      wait_done("rnd");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rnd_product", out_product, exp);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
